// File: rtl/fft_r22sdf_bfii.sv
// Radix-2^2 SDF BFII: -j rotation plus L-deep feedback butterfly, self-counted {t,s} control.
// One-cycle registered output, 1 sample/cycle, no backpressure; state freezes on valid_i=0.
module fft_r22sdf_bfii #(
    parameter int DATA_WIDTH    = 25,
    parameter int SHIFT_REG_LEN = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] x_re_i,
    input  logic [DATA_WIDTH-1:0] x_im_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH:0]   z_re_o,
    output logic [DATA_WIDTH:0]   z_im_o,
    output logic [1:0]            ctrl_o
);

    localparam int W         = DATA_WIDTH + 1;
    localparam int LOG2L     = (SHIFT_REG_LEN > 1) ? $clog2(SHIFT_REG_LEN) : 0;
    localparam int CNT_WIDTH = LOG2L + 2;
    localparam logic [CNT_WIDTH-1:0] LAST_WARM = CNT_WIDTH'(SHIFT_REG_LEN - 1);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_primed;
    logic signed [W-1:0]  r_sr_re [SHIFT_REG_LEN];
    logic signed [W-1:0]  r_sr_im [SHIFT_REG_LEN];

    logic                w_s;
    logic                w_t;
    logic signed [W-1:0] w_x_re;
    logic signed [W-1:0] w_x_im;
    logic signed [W-1:0] w_rot_re;
    logic signed [W-1:0] w_rot_im;
    logic signed [W-1:0] w_sr_re;
    logic signed [W-1:0] w_sr_im;
    logic signed [W-1:0] w_sum_re;
    logic signed [W-1:0] w_sum_im;
    logic signed [W-1:0] w_dif_re;
    logic signed [W-1:0] w_dif_im;
    logic signed [W-1:0] w_din_re;
    logic signed [W-1:0] w_din_im;
    logic signed [W-1:0] w_out_re;
    logic signed [W-1:0] w_out_im;

    assign w_s = r_cnt[LOG2L];
    assign w_t = r_cnt[LOG2L+1];

    assign w_x_re = $signed({x_re_i[DATA_WIDTH-1], x_re_i});
    assign w_x_im = $signed({x_im_i[DATA_WIDTH-1], x_im_i});

    // -j*x in the second half of the frame; negating in W bits keeps the most negative input exact
    assign w_rot_re = w_t ? w_x_im  : w_x_re;
    assign w_rot_im = w_t ? -w_x_re : w_x_im;

    assign w_sr_re  = r_sr_re[SHIFT_REG_LEN-1];
    assign w_sr_im  = r_sr_im[SHIFT_REG_LEN-1];
    assign w_sum_re = w_sr_re + w_rot_re;
    assign w_sum_im = w_sr_im + w_rot_im;
    assign w_dif_re = w_sr_re - w_rot_re;
    assign w_dif_im = w_sr_im - w_rot_im;

    assign w_din_re = w_s ? w_dif_re : w_x_re;
    assign w_din_im = w_s ? w_dif_im : w_x_im;
    assign w_out_re = w_s ? w_sum_re : w_sr_re;
    assign w_out_im = w_s ? w_sum_im : w_sr_im;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            valid_o  <= 1'b0;
            z_re_o   <= '0;
            z_im_o   <= '0;
            ctrl_o   <= 2'b00;
            for (int i = 0; i < SHIFT_REG_LEN; i++) begin
                r_sr_re[i] <= '0;
                r_sr_im[i] <= '0;
            end
        end else begin
            // primed uses its pre-update value so the L-th sample itself is still warm-up
            valid_o <= valid_i & r_primed;
            if (valid_i) begin
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
                z_re_o <= w_out_re;
                z_im_o <= w_out_im;
                ctrl_o <= {w_t, w_s};
                if (r_cnt == LAST_WARM) begin
                    r_primed <= 1'b1;
                end
                r_sr_re[0] <= w_din_re;
                r_sr_im[0] <= w_din_im;
                for (int i = 1; i < SHIFT_REG_LEN; i++) begin
                    r_sr_re[i] <= r_sr_re[i-1];
                    r_sr_im[i] <= r_sr_im[i-1];
                end
            end
        end
    end

endmodule
